// File: rtl/scie_pkg.sv
// -----------------------------------------------------------------------------
// scie_pkg
// Shared definitions for the SCIE FIR sequencer:
//   - OPC_COEF / OPC_PUSH / OPC_READ : SCIE instruction words issued by the
//     sequencer (load a coefficient, push a sample, read the filter result).
//   - seq_state_e                    : sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package scie_pkg;

  localparam logic [31:0] OPC_COEF = 32'd11;
  localparam logic [31:0] OPC_PUSH = 32'd43;
  localparam logic [31:0] OPC_READ = 32'd91;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_GAP  = 3'd2,
    ST_READ = 3'd3,
    ST_WAIT = 3'd4,
    ST_OUT  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/scie_seq_fifo.sv
// -----------------------------------------------------------------------------
// scie_seq_fifo
// Synchronous sample buffer, DATA_W x DEPTH (DEPTH a power of two, >= 2).
// Head is presented combinationally (show-ahead); there is no bypass, so a
// sample written this cycle is visible at the head the next cycle at earliest.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the buffer)
//   push_i, data_i write request and data (ignored while full)
//   pop_i          remove head (ignored while empty)
//   head_o         oldest entry
//   full_o,empty_o occupancy flags
// -----------------------------------------------------------------------------
module scie_seq_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/scie_fir_sequencer.sv
// -----------------------------------------------------------------------------
// scie_fir_sequencer
// Drives an SCIE FIR accelerator: loads coefficients (COEF), and for every
// buffered sample issues PUSH, one idle gap cycle, READ, waits RD_LAT cycles
// for io_scie_rd, and presents the result on the output handshake.
//
// Handshakes (cfg, in, out): a transfer happens on a rising clock edge where
// valid && ready are both 1; the sender holds valid and payload stable until
// that edge, and ready never depends on the sender's valid.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   io_cfg_valid/ready/idx/coef  coefficient load; io_cfg_err pulses one cycle
//                                after a load with idx >= NTAPS
//   io_in_valid/ready/data       sample input into the FIFO
//   io_out_valid/ready/data      filter result
//   io_scie_valid/insn/rs1/rs2   SCIE issue (all zero when valid is 0)
//   io_scie_rd                   SCIE result, valid RD_LAT cycles after READ
//   io_dbg_state                 current FSM state (seq_state_e encoding)
//   io_stat_samples/stalls       only with SCIE_SEQ_STATS_EN defined: wrapping
//                                counts of delivered results and stalled OUT
//                                cycles
// -----------------------------------------------------------------------------
module scie_fir_sequencer
  import scie_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NTAPS      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_cfg_valid,
  output logic              io_cfg_ready,
  input  logic [7:0]        io_cfg_idx,
  input  logic [DATA_W-1:0] io_cfg_coef,
  output logic              io_cfg_err,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_scie_valid,
  output logic [31:0]       io_scie_insn,
  output logic [31:0]       io_scie_rs1,
  output logic [31:0]       io_scie_rs2,
  input  logic [31:0]       io_scie_rd,
  output logic [2:0]        io_dbg_state
`ifdef SCIE_SEQ_STATS_EN
  ,
  output logic [15:0]       io_stat_samples,
  output logic [15:0]       io_stat_stalls
`endif
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  seq_state_e        state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic              cfg_err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              in_fire;
  logic              cfg_fire;
  logic              idx_ok;

  // Ready outputs are forced low while reset is asserted.
  assign io_cfg_ready = (state_q == ST_IDLE) && !reset;
  assign io_in_ready  = !fifo_full && !reset;
  assign cfg_fire     = io_cfg_valid && io_cfg_ready;
  assign in_fire      = io_in_valid && io_in_ready;
  assign idx_ok       = ({24'd0, io_cfg_idx} < 32'(NTAPS));

  scie_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (in_fire),
    .data_i  (io_in_data),
    .pop_i   (state_q == ST_PUSH),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // SCIE issue decode from the registered state. COEF is the only issue that
  // also depends on inputs: it goes out in the same cycle as the cfg transfer.
  always_comb begin
    io_scie_valid = 1'b0;
    io_scie_insn  = '0;
    io_scie_rs1   = '0;
    io_scie_rs2   = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_fire && idx_ok) begin
            io_scie_valid = 1'b1;
            io_scie_insn  = OPC_COEF;
            io_scie_rs1   = 32'(io_cfg_coef);
            io_scie_rs2   = {24'd0, io_cfg_idx};
          end
        end
        ST_PUSH: begin
          io_scie_valid = 1'b1;
          io_scie_insn  = OPC_PUSH;
          io_scie_rs1   = 32'(fifo_head);
        end
        ST_READ: begin
          io_scie_valid = 1'b1;
          io_scie_insn  = OPC_READ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire && !idx_ok;
      case (state_q)
        ST_IDLE: begin
          // A presented cfg beat wins over a buffered sample.
          if (!io_cfg_valid && !fifo_empty) state_q <= ST_PUSH;
        end
        ST_PUSH: state_q <= ST_GAP;
        ST_GAP:  state_q <= ST_READ;
        ST_READ: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Last WAIT cycle is the one where io_scie_rd carries the READ data.
          if (wait_cnt_q == CNT_W'(RD_LAT - 1)) begin
            out_data_q <= DATA_W'(io_scie_rd);
            state_q    <= ST_OUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_OUT: begin
          if (io_out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io_out_valid = (state_q == ST_OUT);
  assign io_out_data  = out_data_q;
  assign io_cfg_err   = cfg_err_q;
  assign io_dbg_state = state_q;

`ifdef SCIE_SEQ_STATS_EN
  logic [15:0] stat_samples_q;
  logic [15:0] stat_stalls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_samples_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (io_out_valid && io_out_ready)  stat_samples_q <= stat_samples_q + 16'd1;
      if (io_out_valid && !io_out_ready) stat_stalls_q  <= stat_stalls_q + 16'd1;
    end
  end

  assign io_stat_samples = stat_samples_q;
  assign io_stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scie_fir_sequencer
// Bench for scie_fir_sequencer. Contains a behavioural SCIE FIR accelerator
// (driven only by the DUT's issue port) and an independent reference filter
// fed from accepted input samples; reference results go into exp_q and are
// compared in order against delivered outputs.
// Build with SCIE_SEQ_STATS_EN defined to also cover the statistics ports.
// -----------------------------------------------------------------------------
module tb_scie_fir_sequencer;
  import scie_pkg::*;

  localparam int DATA_W     = 32;
  localparam int NTAPS      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 1;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic              io_cfg_valid = 1'b0;
  logic              io_cfg_ready;
  logic [7:0]        io_cfg_idx = '0;
  logic [DATA_W-1:0] io_cfg_coef = '0;
  logic              io_cfg_err;
  logic              io_in_valid = 1'b0;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_in_data = '0;
  logic              io_out_valid;
  logic              io_out_ready = 1'b1;
  logic [DATA_W-1:0] io_out_data;
  logic              io_scie_valid;
  logic [31:0]       io_scie_insn;
  logic [31:0]       io_scie_rs1;
  logic [31:0]       io_scie_rs2;
  logic [31:0]       io_scie_rd = '0;
  logic [2:0]        io_dbg_state;
`ifdef SCIE_SEQ_STATS_EN
  logic [15:0]       io_stat_samples;
  logic [15:0]       io_stat_stalls;
`endif

  scie_fir_sequencer #(
    .DATA_W(DATA_W), .NTAPS(NTAPS), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .io_cfg_valid(io_cfg_valid), .io_cfg_ready(io_cfg_ready),
    .io_cfg_idx(io_cfg_idx), .io_cfg_coef(io_cfg_coef), .io_cfg_err(io_cfg_err),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_data(io_in_data),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_data(io_out_data),
    .io_scie_valid(io_scie_valid), .io_scie_insn(io_scie_insn),
    .io_scie_rs1(io_scie_rs1), .io_scie_rs2(io_scie_rs2), .io_scie_rd(io_scie_rd),
    .io_dbg_state(io_dbg_state)
`ifdef SCIE_SEQ_STATS_EN
    , .io_stat_samples(io_stat_samples), .io_stat_stalls(io_stat_stalls)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int out_count = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Reference filter state (bench-owned, updated from stimulus).
  logic [31:0] ref_coef [NTAPS];
  logic [31:0] ref_hist [NTAPS];
  // Accelerator model state (updated only from DUT issues).
  logic [31:0] scie_coef [NTAPS];
  logic [31:0] scie_hist [NTAPS];
  logic [31:0] rd_pending = '0;
  int          rd_cnt = 0;

  initial begin
    for (int i = 0; i < NTAPS; i++) begin
      ref_coef[i] = '0; ref_hist[i] = '0; scie_coef[i] = '0; scie_hist[i] = '0;
    end
  end

  function automatic logic [31:0] ref_dot();
    logic [31:0] acc = '0;
    for (int i = 0; i < NTAPS; i++) acc = acc + ref_coef[i] * ref_hist[i];
    return acc;
  endfunction

  function automatic logic [31:0] scie_dot();
    logic [31:0] acc = '0;
    for (int i = 0; i < NTAPS; i++) acc = acc + scie_coef[i] * scie_hist[i];
    return acc;
  endfunction

  // SCIE accelerator model: result appears RD_LAT cycles after READ; until
  // then io_scie_rd holds a poison value so an early capture is visible.
  always @(negedge clock) begin
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) io_scie_rd = rd_pending;
    end
    if (io_scie_valid) begin
      if (io_scie_insn == OPC_COEF) begin
        if (io_scie_rs2 < NTAPS) scie_coef[io_scie_rs2] = io_scie_rs1;
      end else if (io_scie_insn == OPC_PUSH) begin
        for (int i = NTAPS - 1; i > 0; i--) scie_hist[i] = scie_hist[i-1];
        scie_hist[0] = io_scie_rs1;
      end else if (io_scie_insn == OPC_READ) begin
        rd_pending = scie_dot();
        rd_cnt     = RD_LAT;
        io_scie_rd = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard: push reference result per accepted sample, pop per result.
  always @(negedge clock) begin
    if (!reset) begin
      if (io_in_valid && io_in_ready) begin
        for (int i = NTAPS - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
        ref_hist[0] = io_in_data;
        exp_q.push_back(ref_dot());
      end
      if (io_out_valid && io_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %0d, required no result", io_out_data);
        end else begin
          logic [DATA_W-1:0] exp;
          exp = exp_q.pop_front();
          if (io_out_data !== exp) begin
            errors++;
            $display("FAIL out_data[%0d]: got %0d, required %0d", out_count, io_out_data, exp);
          end
        end
        out_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_samples(input logic [31:0] smp[$], output bit saw_full);
    int idx = 0;
    int cyc = 0;
    saw_full = 0;
    while (idx < smp.size() && cyc < 100) begin
      @(posedge clock); #1;
      io_in_valid = 1'b1;
      io_in_data  = smp[idx];
      @(negedge clock);
      if (io_in_ready) idx++;
      else saw_full = 1;
      cyc++;
    end
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    checks++;
    if (idx != smp.size()) begin
      errors++;
      $display("FAIL drive_samples: accepted %0d, required %0d", idx, smp.size());
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge clock); #1;
      cyc++;
    end while (!(io_dbg_state == ST_IDLE && exp_q.size() == 0) && cyc < 300);
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL wait_idle: state %0d pending %0d, required idle and 0", io_dbg_state, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (io_in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b, required 0", io_in_ready); end
    checks++; if (io_cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready: got %b, required 0", io_cfg_ready); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", io_out_valid); end
    checks++; if (io_out_data !== '0)    begin errors++; $display("FAIL rst_out_data: got %0d, required 0", io_out_data); end
    checks++; if (io_cfg_err !== 1'b0)   begin errors++; $display("FAIL rst_cfg_err: got %b, required 0", io_cfg_err); end
    checks++; if (io_scie_valid !== 1'b0) begin errors++; $display("FAIL rst_scie_valid: got %b, required 0", io_scie_valid); end
    checks++; if (io_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required %0d", io_dbg_state, ST_IDLE); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (io_in_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", io_in_ready); end
    checks++; if (io_cfg_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cfg_ready: got %b, required 1", io_cfg_ready); end
  endtask

  task automatic test_single_sample();
    bit found = 0;
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b1;
    io_in_data  = 28;
    @(negedge clock);
    checks++; if (io_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b, required 1", io_in_ready); end
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (io_scie_valid) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL single_push_issue: got no issue, required PUSH within 10 cycles");
    end else begin
      checks++; if (io_scie_insn !== OPC_PUSH) begin errors++; $display("FAIL single_push_insn: got %0d, required 43", io_scie_insn); end
      checks++; if (io_scie_rs1 !== 32'd28)    begin errors++; $display("FAIL single_push_rs1: got %0d, required 28", io_scie_rs1); end
      checks++; if (io_scie_rs2 !== 32'd0)     begin errors++; $display("FAIL single_push_rs2: got %0d, required 0", io_scie_rs2); end
      @(negedge clock);
      checks++; if (io_scie_valid !== 1'b0 || io_scie_insn !== '0) begin errors++; $display("FAIL single_gap: got valid %b insn %0d, required 0 0", io_scie_valid, io_scie_insn); end
      @(negedge clock);
      checks++; if (io_scie_valid !== 1'b1 || io_scie_insn !== OPC_READ) begin errors++; $display("FAIL single_read: got valid %b insn %0d, required 1 91", io_scie_valid, io_scie_insn); end
      checks++; if (io_scie_rs1 !== '0 || io_scie_rs2 !== '0) begin errors++; $display("FAIL single_read_ops: got %0d %0d, required 0 0", io_scie_rs1, io_scie_rs2); end
      for (int i = 0; i < RD_LAT; i++) begin
        @(negedge clock);
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_out: got %b, required 0", io_out_valid); end
      end
      @(negedge clock);
      checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got out_valid %b, required 1", io_out_valid); end
      checks++; if (io_out_data !== '0)    begin errors++; $display("FAIL single_out_data: got %0d, required 0", io_out_data); end
    end
    wait_idle();
  endtask

  task automatic test_cfg_burst();
    logic [31:0] coefs[5] = '{29, 97, 19, 73, 32};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      io_cfg_valid = 1'b1;
      io_cfg_idx   = 8'(i);
      io_cfg_coef  = coefs[i];
      @(negedge clock);
      if (io_cfg_ready) ref_coef[i] = coefs[i];
      checks++; if (io_cfg_ready !== 1'b1)  begin errors++; $display("FAIL cfg_ready[%0d]: got %b, required 1", i, io_cfg_ready); end
      checks++; if (io_scie_valid !== 1'b1 || io_scie_insn !== OPC_COEF) begin errors++; $display("FAIL cfg_issue[%0d]: got valid %b insn %0d, required 1 11", i, io_scie_valid, io_scie_insn); end
      checks++; if (io_scie_rs1 !== coefs[i] || io_scie_rs2 !== 32'(i)) begin errors++; $display("FAIL cfg_ops[%0d]: got %0d %0d, required %0d %0d", i, io_scie_rs1, io_scie_rs2, coefs[i], i); end
      checks++; if (io_cfg_err !== 1'b0)    begin errors++; $display("FAIL cfg_err[%0d]: got %b, required 0", i, io_cfg_err); end
    end
    @(posedge clock); #1;
    io_cfg_valid = 1'b0;
    @(negedge clock);
    checks++; if (io_cfg_err !== 1'b0 || io_scie_valid !== 1'b0) begin errors++; $display("FAIL cfg_after: got err %b valid %b, required 0 0", io_cfg_err, io_scie_valid); end
  endtask

  task automatic test_cfg_err();
    int pulses = 0;
    @(posedge clock); #1;
    io_cfg_valid = 1'b1;
    io_cfg_idx   = 8'd7;
    io_cfg_coef  = 32'd55;
    @(negedge clock);
    checks++; if (io_cfg_ready !== 1'b1)  begin errors++; $display("FAIL err_cfg_ready: got %b, required 1", io_cfg_ready); end
    checks++; if (io_scie_valid !== 1'b0) begin errors++; $display("FAIL err_no_issue: got %b, required 0", io_scie_valid); end
    @(posedge clock); #1;
    io_cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        checks++; if (io_cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse_time: got %b, required 1", io_cfg_err); end
      end
      if (io_cfg_err === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL err_pulse_count: got %0d, required 1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] smp[$] = '{28, 63, 66, 52, 46};
    bit saw_full;
    int base = out_count;
    io_out_ready = 1'b1;
    drive_samples(smp, saw_full);
    @(negedge clock);
    if (!io_in_ready) saw_full = 1;
    checks++; if (!saw_full) begin errors++; $display("FAIL b2b_full: got in_ready never low, required a full FIFO"); end
    wait_idle();
    checks++; if (out_count - base != 5) begin errors++; $display("FAIL b2b_count: got %0d results, required 5", out_count - base); end
  endtask

  task automatic test_stall();
    logic [31:0] smp[$] = '{11, 200};
    bit saw_full;
    bit found = 0;
    logic [DATA_W-1:0] held;
    io_out_ready = 1'b0;
    drive_samples(smp, saw_full);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (io_out_valid) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_out_valid: got no result, required one within 30 cycles");
    end else begin
      held = io_out_data;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clock);
        checks++; if (io_out_valid !== 1'b1 || io_out_data !== held) begin errors++; $display("FAIL stall_hold[%0d]: got valid %b data %0d, required 1 %0d", i, io_out_valid, io_out_data, held); end
        checks++; if (io_scie_valid !== 1'b0) begin errors++; $display("FAIL stall_no_issue[%0d]: got insn %0d, required no issue", i, io_scie_insn); end
      end
    end
    @(posedge clock); #1;
    io_out_ready = 1'b1;
    @(negedge clock);
`ifdef SCIE_SEQ_STATS_EN
    checks++; if (io_stat_stalls !== 16'd10) begin errors++; $display("FAIL stat_stalls: got %0d, required 10", io_stat_stalls); end
`endif
    wait_idle();
`ifdef SCIE_SEQ_STATS_EN
    checks++; if (io_stat_samples !== 16'(out_count)) begin errors++; $display("FAIL stat_samples: got %0d, required %0d", io_stat_samples, out_count); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] smp[$] = '{5, 6, 7};
    bit saw_full;
    bit found = 0;
    int issues = 0;
    int outs = 0;
    io_out_ready = 1'b1;
    drive_samples(smp, saw_full);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (io_dbg_state == ST_GAP) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_gap: got state %0d, required GAP within 20 cycles", io_dbg_state); end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (io_dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_state: got %0d, required IDLE", io_dbg_state); end
    checks++; if (io_out_valid !== 1'b0)    begin errors++; $display("FAIL mid_out_valid: got %b, required 0", io_out_valid); end
`ifdef SCIE_SEQ_STATS_EN
    checks++; if (io_stat_samples !== '0 || io_stat_stalls !== '0) begin errors++; $display("FAIL mid_stats: got %0d %0d, required 0 0", io_stat_samples, io_stat_stalls); end
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (io_scie_valid) issues++;
      if (io_out_valid) outs++;
    end
    checks++; if (issues != 0 || outs != 0) begin errors++; $display("FAIL mid_discard: got %0d issues %0d results, required 0 0", issues, outs); end
    // Resync the reference history with what the accelerator actually saw.
    for (int i = 0; i < NTAPS; i++) ref_hist[i] = scie_hist[i];
    smp = '{99};
    drive_samples(smp, saw_full);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (io_scie_valid && io_scie_insn == OPC_PUSH) found = 1;
    end
    checks++; if (!found || io_scie_rs1 !== 32'd99) begin errors++; $display("FAIL mid_next_push: got found %b rs1 %0d, required 1 99", found, io_scie_rs1); end
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_single_sample();
    test_cfg_burst();
    test_cfg_err();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending results, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
